// File: rtl/mpsoc4d_ahb4_ext_responder.sv
// AHB4 external-memory responder: a single-port word memory behind an AHB-lite
// slave interface with optional fixed data-phase wait states, two-cycle ERROR
// responses, byte-lane writes and write-to-read forwarding.
`timescale 1ns/1ps

module mpsoc4d_ahb4_ext_responder #(
    parameter int               PLEN        = 32,
    parameter int               XLEN        = 32,
    parameter int               MEM_WORDS   = 1024,
    parameter logic [PLEN-1:0]  BASE_ADDR   = 32'h8000_0000,
    parameter int               WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ahb4_hsel_i,
    input  logic [PLEN-1:0] ahb4_haddr_i,
    input  logic [XLEN-1:0] ahb4_hwdata_i,
    input  logic            ahb4_hwrite_i,
    input  logic [2:0]      ahb4_hsize_i,
    input  logic [2:0]      ahb4_hburst_i,
    input  logic [3:0]      ahb4_hprot_i,
    input  logic [1:0]      ahb4_htrans_i,
    input  logic            ahb4_hmastlock_i,
    output logic [XLEN-1:0] ahb4_hrdata_o,
    output logic            ahb4_hready_o,
    output logic            ahb4_hresp_o
);

    localparam int              IDX_W     = $clog2(MEM_WORDS);
    localparam logic [PLEN:0]   ADDR_END  = {1'b0, BASE_ADDR} + (PLEN+1)'(4 * MEM_WORDS);
    localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_STATES);
    localparam bit              HAS_WAIT  = (WAIT_STATES > 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;

    // Registered data-phase view of the accepted transfer.
    logic             d_valid;
    logic             d_write;
    logic [IDX_W-1:0] d_idx;
    logic [3:0]       d_be;

    logic [XLEN-1:0]  mem [MEM_WORDS];
    logic [XLEN-1:0]  rd_word;

    logic             accept;
    logic [PLEN-1:0]  a_offset;
    logic             a_in_range;
    logic             a_misaligned;
    logic             a_err;
    logic [IDX_W-1:0] a_idx;
    logic [3:0]       a_be;
    logic             d_final;
    logic             commit;
    logic             fwd_hit;
    logic [XLEN-1:0]  merged;

    // Signals the interface deliberately ignores.
    logic             unused_inputs;
    assign unused_inputs = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i, ahb4_htrans_i[0],
                             a_offset[PLEN-1:IDX_W+2], a_offset[1:0]};

    // Responses depend only on registered state, never on the live inputs.
    assign ahb4_hready_o = (state == ST_IDLE) || (state == ST_ERR2);
    assign ahb4_hresp_o  = (state == ST_ERR1) || (state == ST_ERR2);

    assign accept     = ahb4_hready_o && ahb4_hsel_i && ahb4_htrans_i[1];
    assign a_offset   = ahb4_haddr_i - BASE_ADDR;
    assign a_in_range = ({1'b0, ahb4_haddr_i} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, ahb4_haddr_i} < ADDR_END);
    assign a_err      = !a_in_range || (ahb4_hsize_i > 3'd2) || a_misaligned;
    assign a_idx      = a_offset[IDX_W+1:2];

    // Final data-phase cycle of a good transfer: hready is high and the data is due.
    assign d_final = (state == ST_IDLE) && d_valid;
    assign commit  = d_final && d_write;
    assign fwd_hit = commit && (d_idx == a_idx);

    assign ahb4_hrdata_o = (d_final && !d_write) ? rd_word : '0;

    // Decode size/address into byte lanes and an alignment check.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        a_misaligned = 1'b0;
        a_be         = 4'b0000;
        case (ahb4_hsize_i)
            3'd0: a_be = 4'b0001 << ahb4_haddr_i[1:0];
            3'd1: begin
                a_misaligned = ahb4_haddr_i[0];
                a_be         = ahb4_haddr_i[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                a_misaligned = |ahb4_haddr_i[1:0];
                a_be         = 4'b1111;
            end
            default: a_misaligned = 1'b0;
        endcase
    end

    // Word as it will look once the committing write's byte lanes are merged in.
    always_comb begin
        merged = mem[d_idx];
        for (int b = 0; b < 4; b++) begin
            if (d_be[b]) merged[8*b +: 8] = ahb4_hwdata_i[8*b +: 8];
        end
    end

    // Transfer-control FSM with the wait counter and pending-transfer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            d_valid  <= 1'b0;
            d_write  <= 1'b0;
            d_idx    <= '0;
            d_be     <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        d_valid <= !a_err;
                        d_write <= ahb4_hwrite_i;
                        d_idx   <= a_idx;
                        d_be    <= a_be;
                        if (a_err) begin
                            state <= ST_ERR1;
                        end else if (HAS_WAIT) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        d_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory write on the final data cycle and read capture at address acceptance.
    always_ff @(posedge clk) begin
        // NOTE: the memory array and its read register are not reset; contents survive rst_n and the read data is gated by d_valid.
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) mem[d_idx][8*b +: 8] <= ahb4_hwdata_i[8*b +: 8];
            end
        end
        if (accept && !a_err && !ahb4_hwrite_i) begin
            rd_word <= fwd_hit ? merged : mem[a_idx];
        end
    end

endmodule

// File: tb/tb_mpsoc4d_ahb4_ext_responder.sv
// Self-checking bench: two responders (zero and three wait states) driven by a
// pipelined AHB master engine, checked against a byte-level memory model.
`timescale 1ns/1ps

module tb_mpsoc4d_ahb4_ext_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          use_tbl;
        logic        exp_resp;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } xfer_t;

    typedef struct {
        int    wh;
        xfer_t x;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_sel = 1'b0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_write = 1'b0;
    logic [2:0]  a_size = '0;
    logic [2:0]  a_burst = '0;
    logic [3:0]  a_prot = '0;
    logic [1:0]  a_trans = '0;
    logic        a_lock = 1'b0;
    int          which = 0;

    logic [31:0] rdata0, rdata3, m_rdata;
    logic        ready0, ready3, resp0, resp3, m_ready, m_resp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [2][MW];
    xfer_t       q[$];
    vec_t        tbl [27];

    always #5 clk = ~clk;

    mpsoc4d_ahb4_ext_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ahb4_hsel_i(a_sel && (which == 0)), .ahb4_haddr_i(a_addr), .ahb4_hwdata_i(a_wdata),
        .ahb4_hwrite_i(a_write), .ahb4_hsize_i(a_size), .ahb4_hburst_i(a_burst),
        .ahb4_hprot_i(a_prot), .ahb4_htrans_i(a_trans), .ahb4_hmastlock_i(a_lock),
        .ahb4_hrdata_o(rdata0), .ahb4_hready_o(ready0), .ahb4_hresp_o(resp0)
    );

    mpsoc4d_ahb4_ext_responder #(.MEM_WORDS(MW), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ahb4_hsel_i(a_sel && (which == 1)), .ahb4_haddr_i(a_addr), .ahb4_hwdata_i(a_wdata),
        .ahb4_hwrite_i(a_write), .ahb4_hsize_i(a_size), .ahb4_hburst_i(a_burst),
        .ahb4_hprot_i(a_prot), .ahb4_htrans_i(a_trans), .ahb4_hmastlock_i(a_lock),
        .ahb4_hrdata_o(rdata3), .ahb4_hready_o(ready3), .ahb4_hresp_o(resp3)
    );

    assign m_rdata = (which == 1) ? rdata3 : rdata0;
    assign m_ready = (which == 1) ? ready3 : ready0;
    assign m_resp  = (which == 1) ? resp3  : resp0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: range, size and natural alignment.
    function automatic bit model_err(input xfer_t t);
        longint unsigned a;
        a = 64'(t.addr);
        if (a < 64'(BASE) || a >= 64'(BASE) + 64'(4 * MW)) return 1'b1;
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr - BASE) >> 2);
    endfunction

    // Little-endian: byte k of the transfer lives in lane (addr%4)+k of the word.
    function automatic void model_write(input int wh, input xfer_t t);
        int w, off;
        w   = model_idx(t.addr);
        off = int'(t.addr[1:0]);
        for (int k = 0; k < (1 << t.size); k++) begin
            model_mem[wh][w][8*(off+k) +: 8] = t.wdata[8*(off+k) +: 8];
        end
    endfunction

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic w,
                                 input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic er, input logic [31:0] rd, input int cy);
        xfer_t t;
        t.sel = sel; t.trans = trans; t.write = w; t.size = sz; t.addr = addr; t.wdata = wd;
        t.use_tbl = 1'b1; t.exp_resp = er; t.exp_rdata = rd; t.exp_cycles = cy;
        return t;
    endfunction

    function automatic xfer_t rnd_xfer();
        xfer_t t;
        int    r;
        r       = int'($urandom_range(0, 99));
        t.addr  = BASE + 32'($urandom_range(0, 4 * MW - 1));
        if (r < 5)      t.addr = BASE + 32'(4 * MW) + 32'($urandom_range(0, 15));
        else if (r < 8) t.addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
        t.size  = ($urandom_range(0, 99) < 5) ? 3'd3 : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 99) < 85 && t.size < 3'd3) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
        t.write = 1'($urandom);
        t.wdata = $urandom;
        t.sel   = ($urandom_range(0, 99) < 92);
        t.trans = ($urandom_range(0, 99) < 88) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        t.use_tbl = 1'b0; t.exp_resp = 1'b0; t.exp_rdata = '0; t.exp_cycles = 0;
        return t;
    endfunction

    task automatic drive_idle();
        a_sel = 1'b0; a_trans = 2'b00; a_write = 1'b0; a_size = 3'd0; a_addr = '0;
    endtask

    task automatic drive(input xfer_t t);
        a_sel = t.sel; a_trans = t.trans; a_write = t.write; a_size = t.size; a_addr = t.addr;
        a_burst = 3'($urandom); a_prot = 4'($urandom); a_lock = 1'($urandom);
    endtask

    // Garbage on the address/control lines while the responder is stalled.
    task automatic scramble();
        a_sel = 1'($urandom); a_trans = 2'($urandom); a_write = 1'($urandom);
        a_size = 3'($urandom); a_addr = $urandom;
    endtask

    // Pipelined master: a new address phase every cycle hready is high.
    task automatic run_queue();
        xfer_t       pend, dp;
        bit          pend_v = 0, dp_active = 0, idle_chk = 0, err;
        int          cyc = 0, budget = 20000, ws;
        logic        rdy;
        logic [31:0] exp_rd;
        ws = (which == 1) ? 3 : 0;
        while ((q.size() != 0 || pend_v || dp_active) && budget > 0) begin
            if (pend_v) begin
                dp = pend;
                pend_v = 0;
                if (dp.sel && dp.trans[1]) begin
                    dp_active = 1; cyc = 0;
                end else begin
                    idle_chk = 1;
                end
            end
            rdy = m_ready;
            if (idle_chk) begin
                check("idle_ready", {31'd0, rdy}, 32'd1);
                check("idle_resp", {31'd0, m_resp}, 32'd0);
                check("idle_rdata", m_rdata, 32'd0);
                idle_chk = 0;
            end else if (dp_active) begin
                cyc++;
                err = model_err(dp);
                if (rdy) begin
                    exp_rd = (!err && !dp.write) ? model_mem[which][model_idx(dp.addr)] : 32'd0;
                    if (dp.use_tbl) begin
                        check("tbl_cycles", 32'(cyc), 32'(dp.exp_cycles));
                        check("tbl_resp", {31'd0, m_resp}, {31'd0, dp.exp_resp});
                        check("tbl_rdata", m_rdata, dp.exp_rdata);
                    end else begin
                        check("cycles", 32'(cyc), err ? 32'd2 : 32'(ws + 1));
                        check("resp", {31'd0, m_resp}, {31'd0, err});
                        check("rdata", m_rdata, exp_rd);
                    end
                    a_wdata = dp.wdata;
                    if (!err && dp.write) model_write(which, dp);
                    dp_active = 0;
                end else begin
                    check("wait_resp", {31'd0, m_resp}, {31'd0, err});
                    check("wait_rdata", m_rdata, 32'd0);
                    a_wdata = $urandom;
                end
            end
            if (rdy) begin
                if (q.size() != 0) begin
                    pend = q.pop_front();
                    pend_v = 1;
                    drive(pend);
                end else begin
                    drive_idle();
                end
            end else begin
                scramble();
            end
            tick();
            budget--;
        end
        if (budget == 0) check("queue_timeout", 32'(q.size()) + 32'(pend_v) + 32'(dp_active), 32'd0);
        drive_idle();
    endtask

    // Hard stop if something wedges outside the bounded engine.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors: {which dut, transfer, expected resp/rdata/data-phase cycles}.
        tbl[0]  = '{0, mk(1, 2'b10, 1, 3'd2, BASE + 32'h00, 32'h1122_3344, 0, 32'h0, 1)};
        tbl[1]  = '{0, mk(1, 2'b10, 1, 3'd2, BASE + 32'h04, 32'hDEAD_BEEF, 0, 32'h0, 1)};
        tbl[2]  = '{0, mk(1, 2'b10, 0, 3'd2, BASE + 32'h04, 32'h0,         0, 32'hDEAD_BEEF, 1)};
        tbl[3]  = '{0, mk(1, 2'b10, 1, 3'd2, BASE + 32'h04, 32'h0,         0, 32'h0, 1)};
        tbl[4]  = '{0, mk(1, 2'b10, 1, 3'd0, BASE + 32'h06, 32'hA5A5_A5A5, 0, 32'h0, 1)};
        tbl[5]  = '{0, mk(1, 2'b11, 0, 3'd2, BASE + 32'h04, 32'h0,         0, 32'h00A5_0000, 1)};
        tbl[6]  = '{0, mk(1, 2'b10, 0, 3'd2, BASE + 32'h100, 32'h0,        1, 32'h0, 2)};
        tbl[7]  = '{0, mk(1, 2'b10, 1, 3'd1, BASE + 32'h01, 32'hFFFF_FFFF, 1, 32'h0, 2)};
        tbl[8]  = '{0, mk(1, 2'b10, 0, 3'd2, BASE + 32'h00, 32'h0,         0, 32'h1122_3344, 1)};
        tbl[9]  = '{0, mk(1, 2'b10, 0, 3'd2, BASE - 32'd4, 32'h0,          1, 32'h0, 2)};
        tbl[10] = '{0, mk(1, 2'b10, 0, 3'd3, BASE + 32'h00, 32'h0,         1, 32'h0, 2)};
        tbl[11] = '{0, mk(1, 2'b10, 1, 3'd2, BASE + 32'h08, 32'h1234_5678, 0, 32'h0, 1)};
        tbl[12] = '{0, mk(1, 2'b10, 0, 3'd2, BASE + 32'h08, 32'h0,         0, 32'h1234_5678, 1)};
        tbl[13] = '{0, mk(1, 2'b10, 1, 3'd1, BASE + 32'h0A, 32'hCAFE_BEEF, 0, 32'h0, 1)};
        tbl[14] = '{0, mk(1, 2'b11, 0, 3'd2, BASE + 32'h08, 32'h0,         0, 32'hCAFE_5678, 1)};
        tbl[15] = '{0, mk(0, 2'b10, 1, 3'd2, BASE + 32'h08, 32'h0,         0, 32'h0, 1)};
        tbl[16] = '{0, mk(1, 2'b01, 1, 3'd2, BASE + 32'h08, 32'h0,         0, 32'h0, 1)};
        tbl[17] = '{0, mk(1, 2'b10, 1, 3'd2, BASE + 32'hFC, 32'hA1B2_C3D4, 0, 32'h0, 1)};
        tbl[18] = '{0, mk(1, 2'b10, 0, 3'd2, BASE + 32'hFC, 32'h0,         0, 32'hA1B2_C3D4, 1)};
        tbl[19] = '{1, mk(1, 2'b10, 1, 3'd2, BASE + 32'h00, 32'hCAFE_F00D, 0, 32'h0, 4)};
        tbl[20] = '{1, mk(1, 2'b10, 0, 3'd2, BASE + 32'h00, 32'h0,         0, 32'hCAFE_F00D, 4)};
        tbl[21] = '{1, mk(1, 2'b10, 0, 3'd2, BASE + 32'h100, 32'h0,        1, 32'h0, 2)};
        tbl[22] = '{1, mk(1, 2'b10, 1, 3'd2, BASE + 32'h20, 32'h0,         0, 32'h0, 4)};
        tbl[23] = '{1, mk(1, 2'b10, 1, 3'd0, BASE + 32'h21, 32'h3333_5A33, 0, 32'h0, 4)};
        tbl[24] = '{1, mk(1, 2'b10, 0, 3'd2, BASE + 32'h20, 32'h0,         0, 32'h0000_5A00, 4)};
        tbl[25] = '{1, mk(1, 2'b10, 1, 3'd2, BASE + 32'h22, 32'hFFFF_FFFF, 1, 32'h0, 2)};
        tbl[26] = '{1, mk(1, 2'b10, 0, 3'd2, BASE + 32'h20, 32'h0,         0, 32'h0000_5A00, 4)};

        // Reset values while rst_n is held low.
        #1;
        check("rst_ready0", {31'd0, ready0}, 32'd1);
        check("rst_resp0", {31'd0, resp0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready3", {31'd0, ready3}, 32'd1);
        check("rst_resp3", {31'd0, resp3}, 32'd0);
        check("rst_rdata3", rdata3, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fill both memories so every model word is known.
        for (int wh = 0; wh < 2; wh++) begin
            which = wh;
            for (int w = 0; w < MW; w++) begin
                q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'(4 * w), $urandom, 0, 32'h0, 0));
                q[q.size()-1].use_tbl = 1'b0;
            end
            run_queue();
        end

        // Directed table.
        which = tbl[0].wh;
        for (int i = 0; i < 27; i++) begin
            if (tbl[i].wh != which) begin
                run_queue();
                which = tbl[i].wh;
            end
            q.push_back(tbl[i].x);
        end
        run_queue();

        // Randomised pipelined traffic against the model.
        for (int wh = 0; wh < 2; wh++) begin
            which = wh;
            for (int i = 0; i < 400; i++) q.push_back(rnd_xfer());
            run_queue();
        end

        // Reset during a wait-stated write: aborted, no commit.
        which = 1;
        q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'h40, 32'h55AA_55AA, 0, 32'h0, 4));
        run_queue();
        a_sel = 1'b1; a_trans = 2'b10; a_write = 1'b1; a_size = 3'd2; a_addr = BASE + 32'h40;
        tick();
        check("rst_mid_stall", {31'd0, m_ready}, 32'd0);
        drive_idle();
        a_wdata = 32'hFFFF_FFFF;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, m_ready}, 32'd1);
        check("rst_mid_resp", {31'd0, m_resp}, 32'd0);
        check("rst_mid_rdata", m_rdata, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h40, 32'h0, 0, 32'h55AA_55AA, 4));
        run_queue();

        // The other responder's memory also survives reset.
        which = 0;
        q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h08, 32'h0, 0, 32'h0, 0));
        q[0].use_tbl = 1'b0;
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpsoc4d_ahb4_ext_responder.md
MPSOC4D_AHB4_EXT_RESPONDER -- requirements
Module: mpsoc4d_ahb4_ext_responder

Interface
REQ-001 SHALL have parameter PLEN, default 32: address width.
REQ-002 SHALL have parameter XLEN, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_WORDS, default 1024: backing-store depth in XLEN words; power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000: first responding byte address.
REQ-005 SHALL have parameter WAIT_STATES, default 0: data-phase wait cycles, range 0..15.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port ahb4_hsel_i, input, 1 bit: responder select.
REQ-009 SHALL have port ahb4_haddr_i, input, PLEN bits: byte address.
REQ-010 SHALL have port ahb4_hwdata_i, input, XLEN bits: write data, sampled in the data phase.
REQ-011 SHALL have port ahb4_hwrite_i, input, 1 bit: 1 = write.
REQ-012 SHALL have port ahb4_hsize_i, input, 3 bits: transfer size.
REQ-013 SHALL have port ahb4_hburst_i, input, 3 bits: burst type; ignored.
REQ-014 SHALL have port ahb4_hprot_i, input, 4 bits: protection; ignored.
REQ-015 SHALL have port ahb4_htrans_i, input, 2 bits: IDLE/BUSY/NONSEQ/SEQ.
REQ-016 SHALL have port ahb4_hmastlock_i, input, 1 bit: lock; ignored.
REQ-017 SHALL have port ahb4_hrdata_o, output, XLEN bits: read data.
REQ-018 SHALL have port ahb4_hready_o, output, 1 bit: transfer done / address phase accepted.
REQ-019 SHALL have port ahb4_hresp_o, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-020 SHALL accept an address phase when ahb4_hready_o=1, ahb4_hsel_i=1 and ahb4_htrans_i[1]=1 (NONSEQ/SEQ); IDLE/BUSY or hsel=0 SHALL yield a zero-wait OKAY with no memory access.
REQ-021 SHALL classify an accepted transfer as ERROR if: address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS); or hsize>2; or the address is not aligned to hsize.
REQ-022 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2: IDLE -> ERR1 on an accepted error; IDLE -> WAIT on an accepted good transfer when WAIT_STATES>0; otherwise remain IDLE, completing in 1 cycle.
REQ-023 In WAIT, a counter loaded with WAIT_STATES SHALL decrement each cycle with ahb4_hready_o=0; at count 1 the next cycle SHALL complete with hready=1, giving WAIT_STATES+1 data-phase cycles.
REQ-024 ERR1 SHALL drive hready=0, hresp=1; ERR2 SHALL drive hready=1, hresp=1, then return to IDLE, or accept a new address phase presented in ERR2; error transfers SHALL NOT modify memory.
REQ-025 A write SHALL commit on the final data-phase cycle (hready=1), using ahb4_hwdata_i sampled in that cycle and byte lanes from hsize/haddr[1:0], little-endian; unselected bytes SHALL remain unchanged.
REQ-026 A read SHALL present the full addressed word on ahb4_hrdata_o during its final data-phase cycle; it SHALL be 0 in all other cycles and for error transfers.
REQ-027 A read whose address phase overlaps the data phase of a write to the same word SHALL return the post-write merged word (forwarding).
REQ-028 Back-to-back pipelined transfers SHALL sustain 1 transfer/cycle when WAIT_STATES=0.
REQ-029 The address and control of an accepted transfer SHALL be registered; input changes while hready=0 SHALL be ignored.

Reset
REQ-030 While rst_n=0: hready=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, pending-transfer registers cleared.
REQ-031 Reset asserted mid-transfer SHALL abort it with no memory commit; memory contents SHALL NOT be reset.
REQ-032 After rst_n deasserts, the first address phase SHALL be accepted on the next rising edge.

Verification
REQ-033 WAIT_STATES=0: write 32'hDEADBEEF to BASE_ADDR+4, then read it back -> each transfer takes 1 data cycle, hresp=0, hrdata=32'hDEADBEEF.
REQ-034 Byte write 8'hA5 to BASE_ADDR+6 over a word holding 32'h0 -> word read back as 32'h00A5_0000.
REQ-035 WAIT_STATES=3: single read -> hready low for exactly 3 cycles, then high with data.
REQ-036 Read at BASE_ADDR+4*MEM_WORDS, and halfword at BASE_ADDR+1 -> each gives hready=0/hresp=1 then hready=1/hresp=1; memory unchanged.
REQ-037 Pipelined NONSEQ write of 32'h1234_5678 to word W immediately followed by a read of W -> read returns 32'h1234_5678.
REQ-038 rst_n pulsed low during a WAIT-state write of 32'hFFFF_FFFF -> hready=1, hresp=0 immediately; a later read shows the old word value.
